// File: rtl/sccb_slave.sv
// -----------------------------------------------------------------------------
// sccb_slave -- SCCB (I2C-style) register-file slave, single clock domain.
//
// SCL/SDA are oversampled on clk through a SYNC_STAGES flop chain. START, STOP
// and SCL edges are decoded from the synchronized values and their 1-clk-delayed
// copies. A master can write a register pointer and then any number of data
// bytes, or read bytes sequentially from the pointer. The pointer
// auto-increments modulo 256. SDA is driven open-drain through sda_oe.
//
// Ports
//   clk       in   sole clock, rising edge
//   reset     in   synchronous, active-high
//   scl_in    in   bus clock (asynchronous to clk)
//   sda_in    in   bus data as seen on the pad (asynchronous to clk)
//   sda_oe    out  1 = pull SDA low, 0 = release
//   wr_valid  out  one-clk pulse per accepted data byte write
//   wr_addr   out  register address of the write
//   wr_data   out  register data of the write
//   dbg_addr  in   side-band register file read address
//   dbg_data  out  regfile[dbg_addr], 1-clk latency
//   busy      out  high from START until STOP
// -----------------------------------------------------------------------------
module sccb_slave #(
    parameter logic [6:0] DEV_ADDR    = 7'h30,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, WAIT_STOP
    } state_t;

    // ---------------- input synchronizers ----------------
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_d1_q, sda_d1_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    // Shift toward the MSB; the top bit is the synchronized value.
    assign scl_sync_d = SYNC_STAGES'({scl_sync_q, scl_in});
    assign sda_sync_d = SYNC_STAGES'({sda_sync_q, sda_in});
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];

    assign scl_rise  =  scl_s & ~scl_d1_q;
    assign scl_fall  = ~scl_s &  scl_d1_q;
    // SCL must be high on both samples so an SDA change coinciding with an
    // SCL edge is never mistaken for START/STOP.
    assign start_det =  scl_s & scl_d1_q &  sda_d1_q & ~sda_s;
    assign stop_det  =  scl_s & scl_d1_q & ~sda_d1_q &  sda_s;

    // ---------------- state ----------------
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;   // previously received bits of the current byte
    logic       phase_q, phase_d;   // ACK states: ACK driven; RDATA: 8th bit sampled
    logic [7:0] ptr_q, ptr_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       wr_valid_q, wr_valid_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;

    logic [7:0] rf_q [256];
    logic [7:0] dbg_data_q;
    logic       rf_we;

    logic [7:0] byte_in;
    logic [7:0] rd_byte;
    logic       last_bit;

    assign byte_in  = {shift_q, sda_s};
    assign rd_byte  = rf_q[ptr_q];
    assign last_bit = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        phase_d    = phase_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rf_we      = 1'b0;

        if (start_det) begin
            state_d   = DEV;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                DEV: if (scl_rise) begin
                    shift_d   = byte_in[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        phase_d = 1'b0;
                        state_d = (byte_in[7:1] == DEV_ADDR) ? DEV_ACK : WAIT_STOP;
                    end
                end
                REG: if (scl_rise) begin
                    shift_d   = byte_in[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        phase_d = 1'b0;
                        ptr_d   = byte_in;
                        state_d = REG_ACK;
                    end
                end
                WDATA: if (scl_rise) begin
                    shift_d   = byte_in[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        phase_d    = 1'b0;
                        rf_we      = 1'b1;
                        wr_valid_d = 1'b1;
                        wr_addr_d  = ptr_q;
                        wr_data_d  = byte_in;
                        ptr_d      = ptr_q + 8'd1;
                        state_d    = WDATA_ACK;
                    end
                end
                DEV_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        // first falling edge after bit 8: pull ACK low
                        sda_oe_d = 1'b1;
                        phase_d  = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        phase_d   = 1'b0;
                        bit_cnt_d = 3'd0;
                        if (state_q == DEV_ACK) begin
                            if (shift_q[0]) begin
                                // read: MSB goes out on the edge that ends ACK
                                state_d  = RDATA;
                                sda_oe_d = ~rd_byte[7];
                            end else begin
                                state_d = REG;
                            end
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) phase_d = 1'b1;
                    end else if (scl_fall) begin
                        if (phase_q) begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = RD_MACK;
                        end else begin
                            // bit_cnt counts bits already clocked out; ~cnt = 7-cnt
                            sda_oe_d = ~rd_byte[~bit_cnt_q];
                        end
                    end
                end
                RD_MACK: if (scl_rise) begin
                    bit_cnt_d = 3'd0;
                    phase_d   = 1'b0;
                    if (!sda_s) begin
                        ptr_d   = ptr_q + 8'd1;
                        state_d = RDATA;
                    end else begin
                        state_d = WAIT_STOP;
                    end
                end
                default: ;  // IDLE, WAIT_STOP: bus ignored, SDA released
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_d1_q   <= 1'b1;
            sda_d1_q   <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            phase_q    <= 1'b0;
            ptr_q      <= 8'd0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_d1_q   <= scl_s;
            sda_d1_q   <= sda_s;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            phase_q    <= phase_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Register file; dbg_data samples the pre-write contents on a same-clk write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) rf_q[i] <= 8'h00;
            dbg_data_q <= 8'h00;
        end else begin
            if (rf_we) rf_q[ptr_q] <= byte_in;
            dbg_data_q <= rf_q[dbg_addr];
        end
    end

    assign sda_oe   = sda_oe_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign dbg_data = dbg_data_q;
    assign busy     = busy_q;

endmodule
